// File: rtl/pulse_width_meas.sv
// rtl/pulse_width_meas.sv - high-time measurement of a synchronized signal with one-deep result register
module pulse_width_meas #(
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_posedge,
  input  logic              a_negedge,
  output logic [CNT_W-1:0]  width,
  output logic              width_sat,
  output logic              width_valid,
  input  logic              width_ready,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             rise_only;
  logic             fall_only;
  logic             done;

  // Simultaneous edge pulses are a protocol violation and are treated as no pulse at all.
  assign rise_only = a_posedge & ~a_negedge;
  assign fall_only = a_negedge & ~a_posedge;
  assign done      = (state == MEASURE) & fall_only;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a lone rising edge in MEASURE restarts in place.
  always_comb begin
    state_next = state;
    busy       = (state == MEASURE);
    case (state)
      IDLE:    if (rise_only) state_next = MEASURE;
      MEASURE: if (fall_only) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // High-time counter: starts at 1 on the rising edge so that the value seen with the
  // falling edge equals the number of high cycles; holds at all-ones and flags saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (rise_only) begin
      cnt <= CNT_W'(1);
      sat <= 1'b0;
    end else if ((state == MEASURE) && !fall_only) begin
      if (cnt == CNT_MAX) begin
        sat <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Result register: loads when empty or being drained this cycle, otherwise counts a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width       <= '0;
      width_sat   <= 1'b0;
      width_valid <= 1'b0;
      drop_cnt    <= '0;
    end else if (done && (!width_valid || width_ready)) begin
      width       <= cnt;
      width_sat   <= sat;
      width_valid <= 1'b1;
    end else begin
      if (done && drop_cnt != DROP_MAX) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
      if (width_valid && width_ready) begin
        width_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_width_meas.sv
// tb/tb_pulse_width_meas.sv - directed self-checking bench for pulse_width_meas
module tb_pulse_width_meas;

  localparam int PERIOD = 10;

  logic        clk;
  logic        rst_n;
  logic        a_posedge;
  logic        a_negedge;
  logic        width_ready;

  logic [15:0] width;
  logic        width_sat;
  logic        width_valid;
  logic        busy;
  logic [7:0]  drop_cnt;

  logic [3:0]  width_s;
  logic        width_sat_s;
  logic        width_valid_s;
  logic        busy_s;
  logic [1:0]  drop_cnt_s;

  int n_checks;
  int n_fail;

  pulse_width_meas #(.CNT_W(16), .DROP_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_posedge   (a_posedge),
    .a_negedge   (a_negedge),
    .width       (width),
    .width_sat   (width_sat),
    .width_valid (width_valid),
    .width_ready (width_ready),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  pulse_width_meas #(.CNT_W(4), .DROP_W(2)) dut_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_posedge   (a_posedge),
    .a_negedge   (a_negedge),
    .width       (width_s),
    .width_sat   (width_sat_s),
    .width_valid (width_valid_s),
    .width_ready (width_ready),
    .busy        (busy_s),
    .drop_cnt    (drop_cnt_s)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Rising-edge pulse, k-1 quiet cycles, falling-edge pulse; returns 1 time unit after the
  // edge that sees the falling pulse.
  task automatic send_pulse(input int k);
    a_posedge = 1'b1;
    tick();
    a_posedge = 1'b0;
    repeat (k - 1) tick();
    a_negedge = 1'b1;
    tick();
    a_negedge = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    a_posedge   = 1'b0;
    a_negedge   = 1'b0;
    width_ready = 1'b1;
    #20;
    n_checks++;
    if ({width, width_sat, width_valid, busy, drop_cnt} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got w=%0d s=%0b v=%0b b=%0b d=%0d expected all zero",
               width, width_sat, width_valid, busy, drop_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    a_posedge = 1'b1;
    tick();
    a_posedge = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy1 got %0b expected 1", busy); end
    tick();
    n_checks++;
    if (busy !== 1'b1 || width_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy2 got busy=%0b valid=%0b expected 1 0", busy, width_valid);
    end
    a_negedge = 1'b1;
    tick();
    a_negedge = 1'b0;
    n_checks++;
    if (width_valid !== 1'b1 || width !== 16'd2 || width_sat !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result got v=%0b w=%0d s=%0b b=%0b expected 1 2 0 0",
               width_valid, width, width_sat, busy);
    end
    tick();
    n_checks++;
    if (width_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL basic_consumed got v=%0b d=%0d expected 0 0", width_valid, drop_cnt);
    end
  endtask

  task automatic test_hold();
    width_ready = 1'b0;
    send_pulse(100);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (width_valid !== 1'b1 || width !== 16'd100 || width_sat !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d] got v=%0b w=%0d s=%0b expected 1 100 0",
                 i, width_valid, width, width_sat);
      end
      tick();
    end
    width_ready = 1'b1;
    tick();
    n_checks++;
    if (width_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release got v=%0b expected 0", width_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    send_pulse(30);
    n_checks++;
    if (width !== 16'd30 || width_sat !== 1'b0) begin
      n_fail++; $display("FAIL sat_wide got w=%0d s=%0b expected 30 0", width, width_sat);
    end
    n_checks++;
    if (width_valid_s !== 1'b1 || width_s !== 4'd15 || width_sat_s !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_narrow got v=%0b w=%0d s=%0b expected 1 15 1", width_valid_s, width_s, width_sat_s);
    end
    tick();
    send_pulse(15);
    n_checks++;
    if (width_s !== 4'd15 || width_sat_s !== 1'b0) begin
      n_fail++; $display("FAIL sat_edge got w=%0d s=%0b expected 15 0", width_s, width_sat_s);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    width_ready = 1'b0;
    send_pulse(3);
    repeat (2) tick();
    send_pulse(7);
    n_checks++;
    if (width !== 16'd3 || width_valid !== 1'b1 || drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL b2b_drop got w=%0d v=%0b d=%0d expected 3 1 1", width, width_valid, drop_cnt);
    end
    do_reset();
    width_ready = 1'b0;
    send_pulse(3);
    repeat (2) tick();
    a_posedge = 1'b1;
    tick();
    a_posedge = 1'b0;
    repeat (6) tick();
    a_negedge   = 1'b1;
    width_ready = 1'b1;
    tick();
    a_negedge = 1'b0;
    n_checks++;
    if (width !== 16'd7 || width_valid !== 1'b1 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_replace got w=%0d v=%0b d=%0d expected 7 1 0", width, width_valid, drop_cnt);
    end
    tick();
    n_checks++;
    if (width_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain got v=%0b expected 0", width_valid);
    end
  endtask

  task automatic test_restart();
    do_reset();
    width_ready = 1'b1;
    a_posedge = 1'b1;
    tick();
    a_posedge = 1'b0;
    repeat (3) tick();
    a_posedge = 1'b1;
    tick();
    a_posedge = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || width_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL restart_mid got b=%0b v=%0b d=%0d expected 1 0 0", busy, width_valid, drop_cnt);
    end
    repeat (5) tick();
    a_negedge = 1'b1;
    tick();
    a_negedge = 1'b0;
    n_checks++;
    if (width !== 16'd6 || width_valid !== 1'b1) begin
      n_fail++; $display("FAIL restart_width got w=%0d v=%0b expected 6 1", width, width_valid);
    end
    tick();
    a_negedge = 1'b1;
    tick();
    a_negedge = 1'b0;
    tick();
    n_checks++;
    if (width_valid !== 1'b0 || busy !== 1'b0 || width !== 16'd6) begin
      n_fail++;
      $display("FAIL idle_negedge got v=%0b b=%0b w=%0d expected 0 0 6", width_valid, busy, width);
    end
    a_posedge = 1'b1;
    a_negedge = 1'b1;
    tick();
    a_posedge = 1'b0;
    a_negedge = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL both_edges_idle got b=%0b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_posedge = 1'b1;
    tick();
    a_posedge = 1'b0;
    repeat (49) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || width_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_async got b=%0b v=%0b expected 0 0", busy, width_valid);
    end
    tick();
    rst_n = 1'b1;
    a_negedge = 1'b1;
    tick();
    a_negedge = 1'b0;
    tick();
    n_checks++;
    if ({width, width_sat, width_valid, busy, drop_cnt} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_mid got w=%0d s=%0b v=%0b b=%0b d=%0d expected all zero",
               width, width_sat, width_valid, busy, drop_cnt);
    end
  endtask

  task automatic test_drop_sat();
    do_reset();
    width_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_pulse(2);
      tick();
    end
    n_checks++;
    if (drop_cnt !== 8'd5 || width !== 16'd2) begin
      n_fail++; $display("FAIL drop_wide got d=%0d w=%0d expected 5 2", drop_cnt, width);
    end
    n_checks++;
    if (drop_cnt_s !== 2'd3) begin
      n_fail++; $display("FAIL drop_narrow_sat got d=%0d expected 3", drop_cnt_s);
    end
    width_ready = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_hold();
    test_saturation();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    test_drop_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
